// File: rtl/instr_queue_if.sv
// instr_queue_if: fetch-to-decode handshake bundle for instr_queue.
// slave = queue side; master = re-aligner/decode side driving it.
interface instr_queue_if #(
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_WIDTH      = 64
);
  logic                                  flush_i;
  logic [INSTR_PER_FETCH-1:0]            valid_i;
  logic [INSTR_PER_FETCH-1:0][31:0]      instr_i;
  logic [INSTR_PER_FETCH-1:0][ADDR_WIDTH-1:0] addr_i;
  logic                                  ready_o;
  logic                                  valid_o;
  logic [31:0]                           instr_o;
  logic [ADDR_WIDTH-1:0]                 addr_o;
  logic                                  is_compressed_o;
  logic                                  ready_i;
  logic [$clog2(DEPTH):0]                count_o;

  modport slave (
    input  flush_i, valid_i, instr_i, addr_i, ready_i,
    output ready_o, valid_o, instr_o, addr_o,
           is_compressed_o, count_o
  );

  modport master (
    output flush_i, valid_i, instr_i, addr_i, ready_i,
    input  ready_o, valid_o, instr_o, addr_o,
           is_compressed_o, count_o
  );
endinterface

// File: rtl/instr_queue.sv
// instr_queue: compacting fetch FIFO, sparse multi-slot push, 1/cycle pop.
// Ports: clk_i, rst_i (sync, active-high), q (instr_queue_if.slave).
// Optional INSTR_QUEUE_BYPASS_EN: same-cycle head bypass when empty.
module instr_queue #(
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned ADDR_WIDTH      = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  instr_queue_if.slave q
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] IPF_C   = CW'(INSTR_PER_FETCH);

  logic [31:0]           instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [CW-1:0] npush;
  logic [CW-1:0] nwr;
  logic [PW-1:0] slot_off [INSTR_PER_FETCH];
  logic [PW-1:0] wr_idx   [INSTR_PER_FETCH];
  logic [INSTR_PER_FETCH-1:0] wr_en;
  logic [INSTR_PER_FETCH-1:0] skip;
  logic ready;
  logic push;
  logic pop;
  logic byp_take;

  // Slot s lands at wr_ptr + (number of valid slots below s).
  always_comb begin
    npush = '0;
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      slot_off[s] = npush[PW-1:0];
      npush = npush + CW'(q.valid_i[s]);
    end
  end

  // Credit comes from the registered count only.
  assign ready = (DEPTH_C - count) >= IPF_C;
  assign push  = ready && (|q.valid_i) && !q.flush_i;
  assign pop   = (count != '0) && q.ready_i && !q.flush_i;

`ifdef INSTR_QUEUE_BYPASS_EN
  localparam int unsigned LW =
    (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;

  logic [LW-1:0] low;
  logic          byp;

  always_comb begin
    low = '0;
    for (int s = INSTR_PER_FETCH - 1; s >= 0; s--)
      if (q.valid_i[s]) low = LW'(s);
  end

  // push already excludes flush, so a flush kills the bypass.
  assign byp      = push && (count == '0);
  assign byp_take = byp && q.ready_i;

  always_comb begin
    skip = '0;
    if (byp_take) skip[low] = 1'b1;
  end

  assign q.valid_o = (count != '0) || byp;
  assign q.instr_o = byp ? q.instr_i[low] : instr_mem[rd_ptr];
  assign q.addr_o  = byp ? q.addr_i[low]  : addr_mem[rd_ptr];
`else
  assign byp_take  = 1'b0;
  assign skip      = '0;
  assign q.valid_o = (count != '0);
  assign q.instr_o = instr_mem[rd_ptr];
  assign q.addr_o  = addr_mem[rd_ptr];
`endif

  // A bypassed slot is always the lowest, so the rest shift down by one.
  always_comb begin
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      wr_en[s]  = push && q.valid_i[s] && !skip[s];
      wr_idx[s] = wr_ptr + slot_off[s] - PW'(byp_take);
    end
  end

  assign nwr = push ? (npush - CW'(byp_take)) : '0;

  assign q.ready_o         = ready;
  assign q.count_o         = count;
  assign q.is_compressed_o = (q.instr_o[1:0] != 2'b11);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      wr_ptr <= wr_ptr + nwr[PW-1:0];
      count  <= count + nwr - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < INSTR_PER_FETCH; s++) begin
      if (wr_en[s]) begin
        instr_mem[wr_idx[s]] <= q.instr_i[s];
        addr_mem[wr_idx[s]]  <= q.addr_i[s];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i)
    if (!rst_i) assert (count <= DEPTH_C);
`endif

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: scoreboard bench for instr_queue.
// Expected head entries are queued on push and compared on pop.
module tb_instr_queue;
  localparam int IPF   = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 64;
`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [IPF-1:0][31:0] ins_t;
  typedef logic [IPF-1:0][AW-1:0] adr_t;
  typedef struct packed {
    logic [31:0]   ins;
    logic [AW-1:0] ad;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_queue_if #(
    .INSTR_PER_FETCH(IPF), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) qif ();

  instr_queue #(
    .INSTR_PER_FETCH(IPF), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .q(qif)
  );

  ent_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check combinational view at negedge, update model.
  task automatic step(input logic [IPF-1:0] v, input ins_t ins,
                      input adr_t ad, input logic rdy, input logic fl);
    bit   mrdy, mpush, byp, take, hv;
    int   low;
    ent_t h;
    qif.valid_i = v;
    qif.instr_i = ins;
    qif.addr_i  = ad;
    qif.ready_i = rdy;
    qif.flush_i = fl;
    @(negedge clk);
    mrdy  = (DEPTH - sb.size()) >= IPF;
    mpush = mrdy && (v != '0) && !fl;
    byp   = BYP && mpush && (sb.size() == 0);
    low = 0;
    for (int s = IPF - 1; s >= 0; s--) if (v[s]) low = s;
    chk("ready", 64'(qif.ready_o), 64'(mrdy));
    chk("count", 64'(qif.count_o), 64'(sb.size()));
    take = 1'b0;
    if (!fl) begin
      hv = (sb.size() != 0) || byp;
      chk("valid", 64'(qif.valid_o), 64'(hv));
      if (hv) begin
        if (byp) begin
          h.ins = ins[low];
          h.ad  = ad[low];
        end else begin
          h = sb[0];
        end
        chk("addr", qif.addr_o, h.ad);
        chk("instr", 64'(qif.instr_o), 64'(h.ins));
        chk("rvc", 64'(qif.is_compressed_o),
            64'(h.ins[1:0] != 2'b11));
        if (rdy) begin
          if (byp) take = 1'b1;
          else void'(sb.pop_front());
        end
      end
    end
    if (fl) begin
      sb.delete();
    end else if (mpush) begin
      for (int s = 0; s < IPF; s++) begin
        if (v[s] && !(take && s == low)) begin
          h.ins = ins[s];
          h.ad  = ad[s];
          sb.push_back(h);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step('0, '0, '0, rdy, 1'b0);
  endtask

  function automatic adr_t mk_ad(input logic [AW-1:0] base);
    adr_t a;
    for (int s = 0; s < IPF; s++) a[s] = base + AW'(2 * s);
    return a;
  endfunction

  function automatic ins_t mk_ins(input logic [31:0] seed);
    ins_t x;
    for (int s = 0; s < IPF; s++) begin
      x[s] = seed + 32'(s * 32'h0101_0100);
      if (s[0]) x[s][31:16] = '0;
      else x[s][1:0] = 2'b11;
    end
    return x;
  endfunction

  initial begin
    ins_t ri;
    adr_t ra;
    qif.valid_i = '0;
    qif.instr_i = '0;
    qif.addr_i  = '0;
    qif.ready_i = 1'b0;
    qif.flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();

    // reset state + full push, then drain
    step(4'b1111, mk_ins(32'h00a0_0093), mk_ad(64'h1000), 1'b0, 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b1);
    idle(1'b0);

    // sparse push
    step(4'b1010, mk_ins(32'h1234_5601), mk_ad(64'h2000), 1'b0, 1'b0);
    repeat (2) idle(1'b1);
    idle(1'b0);

    // fill to 5, push refused while ready_o=0
    step(4'b1111, mk_ins(32'h0000_4501), mk_ad(64'h4000), 1'b0, 1'b0);
    step(4'b0001, mk_ins(32'h0000_0013), mk_ad(64'h4100), 1'b0, 1'b0);
    step(4'b1111, mk_ins(32'hdead_0003), mk_ad(64'h4200), 1'b0, 1'b0);
    step(4'b1111, mk_ins(32'hbeef_0003), mk_ad(64'h4300), 1'b1, 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b1);

    // wrap: move pointers to 6, then push across the end
    idle(1'b0);
    step('0, '0, '0, 1'b0, 1'b1);
    step(4'b1111, mk_ins(32'h0040_0093), mk_ad(64'h5000), 1'b0, 1'b0);
    step(4'b0011, mk_ins(32'h0050_0093), mk_ad(64'h5100), 1'b0, 1'b0);
    repeat (6) idle(1'b1);
    step(4'b1111, mk_ins(32'h0060_0093), mk_ad(64'h6000), 1'b0, 1'b0);
    repeat (5) idle(1'b1);

    // simultaneous push/pop, then flush with push+pop asserted
    step(4'b0111, mk_ins(32'h0070_0093), mk_ad(64'h7000), 1'b0, 1'b0);
    step(4'b0111, mk_ins(32'h0080_0093), mk_ad(64'h7100), 1'b1, 1'b0);
    step(4'b1111, mk_ins(32'h0090_0093), mk_ad(64'h7200), 1'b1, 1'b1);
    idle(1'b0);

    // single-slot push into empty queue with decode ready
    step(4'b0001, mk_ins(32'h0000_4101), mk_ad(64'h3000), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < IPF; s++) begin
        ri[s] = $urandom;
        ra[s] = {32'($urandom), 32'($urandom)};
      end
      step(4'($urandom_range(0, 15)), ri, ra,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 24) == 0));
    end

    // reset in the middle of a burst
    step(4'b1111, mk_ins(32'h00b0_0093), mk_ad(64'h8000), 1'b0, 1'b0);
    qif.valid_i = 4'b1111;
    qif.ready_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    idle(1'b0);
    step(4'b0101, mk_ins(32'h00c0_0093), mk_ad(64'h9000), 1'b0, 1'b0);
    repeat (3) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
